// File: rtl/rc_pwm_decoder.sv
// rc_pwm_decoder: single-channel RC PWM decoder (width in us, clamp, failsafe); define RC_PWM_DECODER_AVG_EN for two-sample averaging
module rc_pwm_decoder #(
  parameter int CLK_DIV = 133,
  parameter int VAL_WIDTH = 14,
  parameter int MIN_US = 1000,
  parameter int MAX_US = 2000,
  parameter int GLITCH_US = 500,
  parameter int MAX_PULSE_US = 2500,
  parameter int TIMEOUT_US = 25000
) (
  input  logic                 sys_clk,
  input  logic                 resetn,
  input  logic                 pwm_in,
  output logic [VAL_WIDTH-1:0] value,
  output logic                 value_valid,
  output logic                 failsafe,
  output logic                 pulse_error
);
  localparam int PW = $clog2(CLK_DIV + 1);
  localparam logic [PW-1:0] P_TOP = PW'(CLK_DIV - 1);
  localparam logic [11:0] GL = 12'(GLITCH_US);
  localparam logic [11:0] MN = 12'(MIN_US);
  localparam logic [11:0] MX = 12'(MAX_US);
  localparam logic [11:0] MP = 12'(MAX_PULSE_US);
  localparam logic [11:0] SPAN = 12'(MAX_US - MIN_US);
  localparam logic [14:0] TO = 15'(TIMEOUT_US);
  typedef enum logic [1:0] {WAIT_LOW, ARMED, HIGH, EVAL} state_t;
  state_t state, state_d;
  logic s1, s2, s3, rise, fall, us_tick, accept, reject, fs_hit;
  logic [PW-1:0] presc;
  logic [11:0] width, clamped, outv;
  logic [14:0] tcnt, tcnt_d;
  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;
  assign us_tick = presc == P_TOP;
  assign clamped = width < MN ? 12'd0 : width > MX ? SPAN : width - MN;
  always_comb begin
    state_d = state;
    accept = 1'b0;
    reject = 1'b0;
    case (state)
      WAIT_LOW: state_d = s2 ? WAIT_LOW : ARMED;
      ARMED:    state_d = rise ? HIGH : ARMED;
      HIGH: begin
        reject = width >= MP;
        state_d = reject ? WAIT_LOW : fall ? EVAL : HIGH;
      end
      EVAL: begin
        reject = width < GL;
        accept = ~reject;
        state_d = rise ? HIGH : ARMED;
      end
    endcase
    tcnt_d = accept ? 15'd0 : (us_tick && tcnt != TO) ? tcnt + 15'd1 : tcnt;
    fs_hit = tcnt_d == TO;
  end
`ifdef RC_PWM_DECODER_AVG_EN
  logic [11:0] prev;
  logic have_prev;
  logic [12:0] sum;
  assign sum = {1'b0, prev} + {1'b0, clamped};
  assign outv = have_prev ? sum[12:1] : clamped;
  always_ff @(posedge sys_clk)
    if (!resetn || (fs_hit && !accept)) begin
      prev <= '0;
      have_prev <= 1'b0;
    end else if (accept) begin
      prev <= clamped;
      have_prev <= 1'b1;
    end
`else
  assign outv = clamped;
`endif
  always_ff @(posedge sys_clk)
    if (!resetn) begin
      {s1, s2, s3} <= 3'b111;
      state <= WAIT_LOW;
      presc <= '0;
      width <= '0;
      tcnt <= '0;
      value <= '0;
      value_valid <= 1'b0;
      pulse_error <= 1'b0;
      failsafe <= 1'b1;
    end else begin
      {s1, s2, s3} <= {pwm_in, s1, s2};
      state <= state_d;
      presc <= (rise || us_tick) ? '0 : presc + 1'b1;
      width <= rise ? '0 : (us_tick && state == HIGH) ? width + 12'd1 : width;
      tcnt <= tcnt_d;
      value_valid <= accept;
      pulse_error <= reject;
      failsafe <= accept ? 1'b0 : fs_hit ? 1'b1 : failsafe;
      value <= accept ? VAL_WIDTH'(outv) : fs_hit ? '0 : value;
    end
endmodule

// File: tb/tb_rc_pwm_decoder.sv
// tb_rc_pwm_decoder: directed table and corner-case sequences for rc_pwm_decoder
module tb_rc_pwm_decoder;
  localparam int CD = 2;
  typedef struct {int hi; int clamp; int err;} vec_t;
  logic clk = 1'b0, resetn = 1'b0, pwm_in = 1'b0;
  logic [13:0] value;
  logic value_valid, failsafe, pulse_error;
  int cyc = 0, n_valid = 0, n_err = 0, valid_cyc = 0, err_cyc = 0, fall_cyc = 0;
  int n_cmp = 0, n_bad = 0, exp_v = 0;
  vec_t tbl[9];
`ifdef RC_PWM_DECODER_AVG_EN
  int prev = 0;
  bit have = 0;
`endif
  rc_pwm_decoder #(.CLK_DIV(CD), .TIMEOUT_US(6000)) dut (
    .sys_clk(clk), .resetn(resetn), .pwm_in(pwm_in), .value(value),
    .value_valid(value_valid), .failsafe(failsafe), .pulse_error(pulse_error)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (value_valid) begin
      n_valid <= n_valid + 1;
      valid_cyc <= cyc;
    end
    if (pulse_error) begin
      n_err <= n_err + 1;
      err_cyc <= cyc;
    end
  end
  function automatic int model(int c);
`ifdef RC_PWM_DECODER_AVG_EN
    int r = have ? (prev + c) >> 1 : c;
    prev = c;
    have = 1;
    return r;
`else
    return c;
`endif
  endfunction
  task automatic clear_hist();
`ifdef RC_PWM_DECODER_AVG_EN
    have = 0;
`endif
  endtask
  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic pulse(int hi_us, int lo_us);
    @(negedge clk);
    pwm_in = 1'b1;
    repeat (hi_us * CD) @(negedge clk);
    pwm_in = 1'b0;
    fall_cyc = cyc + 1;
    repeat (lo_us * CD) @(negedge clk);
  endtask
  initial begin
    int v0, e0, acc, fs_cyc;
    tbl = '{'{1500, 500, 0}, '{800, 0, 0}, '{2300, 1000, 0}, '{1999, 999, 0}, '{300, 0, 1},
            '{499, 0, 1}, '{1000, 0, 0}, '{2000, 1000, 0}, '{500, 0, 0}};
    repeat (4) @(negedge clk);
    resetn = 1'b1;
    chk("rst_value", int'(value), 0);
    chk("rst_valid", value_valid, 0);
    chk("rst_err", pulse_error, 0);
    chk("rst_failsafe", failsafe, 1);
    repeat (20) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      v0 = n_valid;
      e0 = n_err;
      if (i == 0) chk("pre_failsafe", failsafe, 1);
      pulse(tbl[i].hi, 100);
      if (tbl[i].err == 0) exp_v = model(tbl[i].clamp);
      chk($sformatf("v%0d_valid", i), n_valid - v0, tbl[i].err ? 0 : 1);
      chk($sformatf("v%0d_err", i), n_err - e0, tbl[i].err);
      chk($sformatf("v%0d_value", i), int'(value), exp_v);
      chk($sformatf("v%0d_failsafe", i), failsafe, 0);
      chk($sformatf("v%0d_latency", i), tbl[i].err ? err_cyc : valid_cyc, fall_cyc + 3);
    end
    v0 = n_valid;
    e0 = n_err;
    pulse(3000, 100);
    chk("ovl_err", n_err - e0, 1);
    chk("ovl_valid", n_valid - v0, 0);
    chk("ovl_before_fall", int'(err_cyc < fall_cyc), 1);
    chk("ovl_value_hold", int'(value), exp_v);
    pulse(1200, 100);
    exp_v = model(200);
    chk("after_ovl_valid", n_valid - v0, 1);
    chk("after_ovl_value", int'(value), exp_v);
    pulse(1500, 0);
    repeat (6) @(negedge clk);
    exp_v = model(500);
    chk("to_pre_value", int'(value), exp_v);
    v0 = n_valid;
    acc = valid_cyc;
    fs_cyc = -1;
    for (int i = 0; i < 13000 && fs_cyc < 0; i++) begin
      @(negedge clk);
      if (failsafe) fs_cyc = cyc;
    end
    chk("to_fired", int'(fs_cyc >= 0), 1);
    chk("to_latency", int'(fs_cyc - acc >= 11998 && fs_cyc - acc <= 12002), 1);
    chk("to_value", int'(value), 0);
    chk("to_no_valid", n_valid - v0, 0);
    clear_hist();
    pulse(1100, 100);
    exp_v = model(100);
    chk("fs_exit_valid", n_valid - v0, 1);
    chk("fs_exit_value", int'(value), exp_v);
    chk("fs_exit_failsafe", failsafe, 0);
    @(negedge clk);
    resetn = 1'b0;
    pwm_in = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst2_value", int'(value), 0);
    chk("rst2_failsafe", failsafe, 1);
    resetn = 1'b1;
    clear_hist();
    v0 = n_valid;
    e0 = n_err;
    repeat (700 * CD) @(negedge clk);
    pwm_in = 1'b0;
    repeat (100 * CD) @(negedge clk);
    chk("rst_pulse_valid", n_valid - v0, 0);
    chk("rst_pulse_err", n_err - e0, 0);
    chk("rst_pulse_failsafe", failsafe, 1);
    pulse(1200, 100);
    exp_v = model(200);
    chk("post_rst_a_value", int'(value), exp_v);
    chk("post_rst_a_failsafe", failsafe, 0);
    pulse(1600, 100);
    exp_v = model(600);
    chk("post_rst_b_value", int'(value), exp_v);
    chk("post_rst_valid_count", n_valid - v0, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
